// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. It handles stall, flush and load-use bubbles,
// and forwards results from MEM and WB before the ALU operands are selected.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [3:0]                   id_alu_op,
  input  logic [XLEN-1:0]              id_rs1_data,
  input  logic [XLEN-1:0]              id_rs2_data,
  input  logic [XLEN-1:0]              id_imm,
  input  logic [XLEN-1:0]              id_pc,
  input  logic [REG_ADDR_W-1:0]        id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]        id_rs2_addr,
  input  logic [REG_ADDR_W-1:0]        id_rd_addr,
  input  logic                         id_rs1_used,
  input  logic                         id_rs2_used,
  input  logic [1:0]                   id_a_sel,
  input  logic                         id_b_sel,
  input  logic                         id_reg_write,
  input  logic                         id_mem_read,
  input  logic                         id_mem_write,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [REG_ADDR_W-1:0]        mem_rd_addr,
  input  logic [REG_ADDR_W-1:0]        wb_rd_addr,
  input  logic                         mem_reg_write,
  input  logic                         wb_reg_write,
  input  logic [XLEN-1:0]              mem_result,
  input  logic [XLEN-1:0]              wb_result,
  output logic                         load_use_stall,
  output logic                         ex_valid,
  output logic [3:0]                   ex_alu_op,
  output logic signed [XLEN-1:0]       ex_in_a,
  output logic signed [XLEN-1:0]       ex_in_b,
  output logic [XLEN-1:0]              ex_store_data,
  output logic [XLEN-1:0]              ex_pc,
  output logic [REG_ADDR_W-1:0]        ex_rd_addr,
  output logic                         ex_reg_write,
  output logic                         ex_mem_read,
  output logic                         ex_mem_write
);

  localparam logic [3:0] ALU_ADD = 4'd0;

  logic                  valid_q, reg_write_q, mem_read_q, mem_write_q, b_sel_q;
  logic [3:0]            alu_op_q;
  logic [1:0]            a_sel_q;
  logic [XLEN-1:0]       rs1_q, rs2_q, imm_q, pc_q;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;
  logic                  bubble;

  always_comb begin
    fwd_rs1 = rs1_q;
    if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == rs1_addr_q)
      fwd_rs1 = mem_result;
    else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == rs1_addr_q)
      fwd_rs1 = wb_result;
  end

  always_comb begin
    fwd_rs2 = rs2_q;
    if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == rs2_addr_q)
      fwd_rs2 = mem_result;
    else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == rs2_addr_q)
      fwd_rs2 = wb_result;
  end

  assign load_use_stall = !stall && !flush && ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
                          id_valid && ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
                                       (id_rs2_used && id_rs2_addr == ex_rd_addr));

  // load_use_stall is already gated by stall/flush, so flush always wins here
  assign bubble = flush || load_use_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      alu_op_q    <= ALU_ADD;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      a_sel_q     <= 2'd0;
      b_sel_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (bubble) begin
      valid_q     <= 1'b0;
      alu_op_q    <= ALU_ADD;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      a_sel_q     <= 2'd0;
      b_sel_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (stall) begin
      // Capture forwarded operands so they survive the producer retiring during the hold
      rs1_q <= fwd_rs1;
      rs2_q <= fwd_rs2;
    end else begin
      valid_q     <= id_valid;
      alu_op_q    <= id_alu_op;
      rs1_q       <= id_rs1_data;
      rs2_q       <= id_rs2_data;
      imm_q       <= id_imm;
      pc_q        <= id_pc;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      rd_addr_q   <= id_rd_addr;
      a_sel_q     <= id_a_sel;
      b_sel_q     <= id_b_sel;
      reg_write_q <= id_reg_write & id_valid;
      mem_read_q  <= id_mem_read & id_valid;
      mem_write_q <= id_mem_write & id_valid;
    end
  end

  always_comb begin
    case (a_sel_q)
      2'd0:    ex_in_a = fwd_rs1;
      2'd1:    ex_in_a = pc_q;
      default: ex_in_a = '0;
    endcase
  end

  assign ex_in_b       = b_sel_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_valid      = valid_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_pc         = pc_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = reg_write_q & valid_q;
  assign ex_mem_read   = mem_read_q & valid_q;
  assign ex_mem_write  = mem_write_q & valid_q;

endmodule
